// File: rtl/seed_round_seq.sv
// Start/busy/done round sequencer for the SEED datapath: steps phase and round
// counters on each unstalled clk_en and presents the subkey index for the chosen direction.
module seed_round_seq #(
  parameter int NUM_ROUNDS = 16,
  parameter int PHASES     = 2,
  parameter int ROUND_W    = 4,
  parameter int PHASE_W    = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_en,
  input  logic               start,
  input  logic               mode,
  input  logic               hold,
  output logic [ROUND_W-1:0] round_idx,
  output logic [ROUND_W-1:0] key_idx,
  output logic [PHASE_W-1:0] phase,
  output logic               busy,
  output logic               first_round,
  output logic               last_round,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);
  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(PHASES - 1);

  state_e             state_q, state_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               mode_q, mode_d;
  logic               adv;

  assign adv = clk_en & ~hold;

  // Next-state decode: round and phase are separate counters, phase wraps into round.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    phase_d = phase_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          round_d = {ROUND_W{1'b0}};
          phase_d = {PHASE_W{1'b0}};
          mode_d  = mode;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!adv) begin
          state_d = ST_RUN;
        end else if (phase_q != LAST_PHASE) begin
          phase_d = phase_q + PHASE_W'(1);
        end else if (round_q != LAST_ROUND) begin
          phase_d = {PHASE_W{1'b0}};
          round_d = round_q + ROUND_W'(1);
        end else begin
          // Final advance: counters keep their last values through DONE and IDLE.
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset dominating every input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      round_q <= {ROUND_W{1'b0}};
      phase_q <= {PHASE_W{1'b0}};
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end

  assign round_idx   = round_q;
  assign phase       = phase_q;
  assign key_idx     = mode_q ? (LAST_ROUND - round_q) : round_q;
  assign busy        = (state_q == ST_RUN);
  assign first_round = busy && (round_q == {ROUND_W{1'b0}});
  assign last_round  = busy && (round_q == LAST_ROUND);
  assign done        = (state_q == ST_DONE);

endmodule

// File: doc/seed_round_seq.md
Name: seed_round_seq

Overview:
Parametrised round sequencer for the SEED datapath and key schedule. It replaces the free-running round counter with a start/busy/done controlled sequencer. Added capabilities:
- configurable round count and clk_en ticks per round;
- encrypt/decrypt subkey index ordering;
- stall input;
- first/last-round flags.

It sits between the top-level control (start/done) and the round function and subkey store.

Parameters:
NUM_ROUNDS, 16, rounds per block operation (>=2).
PHASES, 2, clk_en ticks per round (>=1; 2 = two clk_en cycles per round).
ROUND_W, 4, width of round/key index; must satisfy 2**ROUND_W >= NUM_ROUNDS.
PHASE_W, 1, width of phase output; must satisfy 2**PHASE_W >= PHASES (use 1 when PHASES=1).

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
clk_en  in  1  advance strobe (pulses every 2 clk cycles in the current top level)
start  in  1  begin a block operation; honoured only in IDLE
mode  in  1  0 = encrypt, 1 = decrypt; sampled with start
hold  in  1  stall; when high, the sequencer does not advance
round_idx  out  ROUND_W  current round, 0..NUM_ROUNDS-1
key_idx  out  ROUND_W  subkey index: enc = round_idx, dec = NUM_ROUNDS-1-round_idx
phase  out  PHASE_W  sub-round phase, 0..PHASES-1
busy  out  1  high in RUN
first_round  out  1  busy and round_idx==0
last_round  out  1  busy and round_idx==NUM_ROUNDS-1
done  out  1  one clk-cycle pulse at end of operation

Behaviour:
- Reset (sync, active-high, dominates all inputs):
  - state=IDLE, round_idx=0, phase=0, mode_q=0;
  - therefore key_idx=0, busy=0, first_round=0, last_round=0, done=0.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 (clk_en and hold are don't-care) -> RUN next cycle, with round_idx=0, phase=0, mode_q=mode.
  - Otherwise hold. round_idx/phase keep their last values; busy=0 forces first_round/last_round low.
- RUN:
  - The advance condition is adv = clk_en & ~hold.
  - On adv with phase<PHASES-1: phase+1.
  - On adv with phase==PHASES-1 and round_idx<NUM_ROUNDS-1: phase=0, round_idx+1.
  - On adv with phase==PHASES-1 and round_idx==NUM_ROUNDS-1: go to DONE. round_idx and phase hold their final values (NUM_ROUNDS-1, PHASES-1).
  - No adv: all state held. hold has priority over clk_en.
- DONE:
  - done=1 for exactly one clk cycle, busy=0.
  - Unconditional return to IDLE next cycle.
  - start asserted in DONE is ignored; it must be re-asserted in IDLE.
- start in RUN is ignored; mode changes after the start cycle are ignored (mode_q is used).
- Latency:
  - From the start cycle, busy rises on the next clock.
  - The run lasts exactly NUM_ROUNDS*PHASES adv events.
  - done is asserted on the cycle after the final adv.
- Arithmetic:
  - The round counter and phase counter are separate registers, with no division.
  - key_idx is combinational from round_idx and mode_q; the subtraction is ROUND_W bits wide and never wraps.
- Outputs busy/first_round/last_round/done/key_idx are combinational decodes of registered state; they are glitch-free relative to clk.
- Reset mid-operation: the next cycle is IDLE with all outputs at reset values. No done pulse is issued.

Test Plan:
1. Reset, then start(mode=0) with clk_en every 2nd cycle, hold=0 -> busy the next cycle. round_idx steps 0..15, changing every 4 clk. The 32nd adv -> done=1 for 1 cycle, busy=0; total start-to-done = 65 clk. first_round is high only for round 0; last_round is high only for round 15.
2. start with mode=1; toggle mode low one cycle later -> key_idx runs 15,14..0 while round_idx runs 0..15 (decrypt ordering is retained).
3. hold=1 for 10 cycles during round 7, phase 1, with clk_en pulsing -> round_idx stays 7 and phase stays 1. Release hold -> sequence resumes; done arrives exactly 10 cycles later than in scenario 1.
4. Pulse start during RUN (round 3) and during the DONE cycle -> no restart, no second run. round_idx continues monotonically, and exactly one done is produced.
5. Assert reset at round 9 -> next cycle busy=0, round_idx=0, phase=0, done never asserted. A new start then runs a full 32-advance sequence.
6. Instantiate NUM_ROUNDS=4, PHASES=1, ROUND_W=2, PHASE_W=1 with clk_en tied high -> round_idx 0,1,2,3 on consecutive cycles, phase constant 0. done on the 5th cycle after start; decrypt gives key_idx 3,2,1,0.
